// File: rtl/alarm_sched.sv
// Alarm scheduler: NCH compare channels on a shared tick counter,
// pending/overrun tracking and a fixed-priority interrupt vector.
module alarm_sched #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] din,
    input  logic             wen,
    input  logic             cs,
    output logic [WIDTH-1:0] dout,
    input  logic             tick,
    input  logic [WIDTH-1:0] now,
    output logic             irq
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } st_t;

    st_t              st_q [NCH];
    st_t              st_d [NCH];
    logic [WIDTH-1:0] cmp_q [NCH];
    logic [WIDTH-1:0] per_q [NCH];
    logic [NCH-1:0]   en_q, pmode_q, mask_q;
    logic [NCH-1:0]   pend_q, ovr_q;
    logic [NCH-1:0]   fire, reload, cmp_wr, per_wr;
    logic [NCH-1:0]   clr_p, clr_o, ack;
    logic [3:0]       a;
    logic             we;
    logic             vld;
    logic [2:0]       vidx;
    logic             unused;

    assign a      = addr[3:0];
    assign we     = cs & wen;
    assign unused = ^addr[WIDTH-1:4];

    always_comb begin
        vld  = |(pend_q & mask_q);
        vidx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend_q[i] & mask_q[i]) vidx = 3'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cmp_wr[i] = we && (a == 4'(i));
            per_wr[i] = we && (a == 4'(4 + i));
            fire[i]   = tick && (st_q[i] == ARMED) && (now == cmp_q[i]);
            reload[i] = fire[i] && pmode_q[i] && (per_q[i] != '0);
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            st_d[i] = st_q[i];
            if (!en_q[i]) begin
                st_d[i] = IDLE;
            end else begin
                case (st_q[i])
                    IDLE:    st_d[i] = ARMED;
                    ARMED:   if (fire[i] && !reload[i]) st_d[i] = DONE;
                    DONE:    if (cmp_wr[i]) st_d[i] = ARMED;
                    default: st_d[i] = IDLE;
                endcase
            end
        end
    end

    // Clears come from STATUS W1C or a VECTOR ack; a fire in the same cycle overrides them
    always_comb begin
        clr_p = '0;
        clr_o = '0;
        ack   = '0;
        if (we && a == 4'd9) begin
            clr_p = din[NCH-1:0];
            clr_o = din[4+:NCH];
        end
        if (we && a == 4'd10 && vld) ack[vidx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]  <= IDLE;
                cmp_q[i] <= '0;
                per_q[i] <= '0;
            end
            en_q    <= '0;
            pmode_q <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            irq     <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i] <= st_d[i];
                if (cmp_wr[i]) cmp_q[i] <= din;
                else if (reload[i]) cmp_q[i] <= cmp_q[i] + per_q[i];
                if (per_wr[i]) per_q[i] <= din;
            end
            if (we && a == 4'd8) begin
                en_q    <= din[NCH-1:0];
                pmode_q <= din[4+:NCH];
                mask_q  <= din[8+:NCH];
            end
            pend_q <= (pend_q & ~(clr_p | ack)) | fire;
            ovr_q  <= (ovr_q & ~(clr_o | ack)) | (fire & pend_q);
            irq    <= vld;
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < NCH; i++) begin
            if (a == 4'(i)) dout = cmp_q[i];
            if (a == 4'(4 + i)) dout = per_q[i];
        end
        case (a)
            4'd8: begin
                dout[NCH-1:0] = en_q;
                dout[4+:NCH]  = pmode_q;
                dout[8+:NCH]  = mask_q;
            end
            4'd9: begin
                dout[NCH-1:0] = pend_q;
                dout[4+:NCH]  = ovr_q;
            end
            4'd10: begin
                dout[WIDTH-1] = vld;
                dout[2:0]     = vld ? vidx : 3'd0;
            end
            4'd11:   dout = now;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alarm_sched.sv
// Vector table for alarm_sched; read/irq expectations are queued
// as each check is driven and popped when the output is sampled.
module tb_alarm_sched;

    typedef enum {OP_WR, OP_TK, OP_WT, OP_RD, OP_IRQ, OP_NOP, OP_RST} op_e;

    typedef struct {
        op_e         op;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] n;
        logic [31:0] e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic        wen = 1'b0;
    logic        cs = 1'b0;
    logic [31:0] dout;
    logic        tick = 1'b0;
    logic [31:0] now = '0;
    logic        irq;

    vec_t        tbl[$];
    logic [31:0] expq[$];
    int          total = 0;
    int          bad = 0;

    alarm_sched #(.WIDTH(32), .NCH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .din  (din),
        .wen  (wen),
        .cs   (cs),
        .dout (dout),
        .tick (tick),
        .now  (now),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(op_e op, logic [3:0] a, logic [31:0] d,
                                logic [31:0] n, logic [31:0] e);
        vec_t v;
        v = '{op, a, d, n, e};
        tbl.push_back(v);
    endfunction

    function automatic void wr(logic [3:0] a, logic [31:0] d);
        add(OP_WR, a, d, 0, 0);
    endfunction
    function automatic void tk(logic [31:0] n);
        add(OP_TK, 0, 0, n, 0);
    endfunction
    function automatic void wt(logic [3:0] a, logic [31:0] d, logic [31:0] n);
        add(OP_WT, a, d, n, 0);
    endfunction
    function automatic void rd(logic [3:0] a, logic [31:0] e);
        add(OP_RD, a, 0, 0, e);
    endfunction
    function automatic void iq(logic [31:0] e);
        add(OP_IRQ, 0, 0, 0, e);
    endfunction
    function automatic void nop();
        add(OP_NOP, 0, 0, 0, 0);
    endfunction
    function automatic void rst();
        add(OP_RST, 0, 0, 0, 0);
    endfunction

    task automatic check(int idx, string nm, logic [31:0] got);
        logic [31:0] exp;
        exp = expq.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL vec%0d %s got=%h exp=%h", idx, nm, got, exp);
        end
    endtask

    initial begin
        // reset / idle behaviour
        for (int i = 0; i <= 10; i++) rd(4'(i), 0);
        iq(0);
        tk(32'h1234);
        rd(11, 32'h1234);
        wr(12, 32'hff);
        rd(12, 0);
        wr(0, 5);
        for (int n = 0; n <= 10; n++) tk(n);
        rd(9, 0);
        iq(0);
        // one-shot
        rst();
        wr(0, 5);
        wr(8, 32'h101);
        for (int n = 1; n <= 4; n++) tk(n);
        rd(9, 0);
        tk(5);
        rd(9, 1);
        iq(0);
        nop();
        iq(1);
        rd(10, 32'h8000_0000);
        wr(10, 0);
        iq(1);
        nop();
        iq(0);
        rd(9, 0);
        tk(6);
        tk(5);
        rd(9, 0);
        wr(0, 8);
        nop();
        tk(8);
        rd(9, 1);
        // periodic
        rst();
        wr(1, 10);
        wr(5, 4);
        wr(8, 32'h222);
        nop();
        tk(10);
        rd(1, 14);
        rd(9, 2);
        tk(12);
        tk(14);
        rd(1, 18);
        rd(9, 32'h22);
        tk(18);
        rd(1, 22);
        // wrap
        rst();
        wr(2, 32'hffff_fffe);
        wr(6, 3);
        wr(8, 32'h444);
        nop();
        tk(32'hffff_fffe);
        rd(2, 1);
        rd(9, 4);
        wr(9, 4);
        rd(9, 0);
        tk(32'hffff_ffff);
        tk(0);
        rd(9, 0);
        tk(1);
        rd(9, 4);
        rd(2, 4);
        // priority
        rst();
        wr(0, 7);
        wr(3, 7);
        wr(8, 32'h909);
        nop();
        tk(7);
        rd(9, 9);
        nop();
        iq(1);
        rd(10, 32'h8000_0000);
        wr(10, 0);
        rd(10, 32'h8000_0003);
        rd(9, 8);
        wr(10, 0);
        rd(10, 0);
        nop();
        iq(0);
        // races
        rst();
        wr(0, 3);
        wr(4, 2);
        wr(8, 32'h111);
        nop();
        tk(3);
        rd(9, 1);
        rd(0, 5);
        wt(9, 1, 5);
        rd(9, 32'h11);
        rd(0, 7);
        wt(0, 100, 7);
        rd(0, 100);
        rd(9, 32'h11);
        iq(1);
        // reset mid-operation
        rst();
        rd(9, 0);
        rd(0, 0);
        rd(8, 0);
        iq(0);

        for (int i = 0; i < 4; i++) begin
            tick = ~tick;
            now = now + 1;
            step();
        end
        tick = 1'b0;
        reset = 1'b1;
        step();

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_WR: begin
                    cs = 1'b1; wen = 1'b1;
                    addr = {28'd0, tbl[i].a}; din = tbl[i].d;
                    step();
                    cs = 1'b0; wen = 1'b0;
                end
                OP_TK: begin
                    tick = 1'b1; now = tbl[i].n;
                    step();
                    tick = 1'b0;
                end
                OP_WT: begin
                    cs = 1'b1; wen = 1'b1;
                    addr = {28'd0, tbl[i].a}; din = tbl[i].d;
                    tick = 1'b1; now = tbl[i].n;
                    step();
                    cs = 1'b0; wen = 1'b0; tick = 1'b0;
                end
                OP_RD: begin
                    addr = {28'd0, tbl[i].a};
                    expq.push_back(tbl[i].e);
                    #1;
                    check(i, $sformatf("rd%0d", tbl[i].a), dout);
                end
                OP_IRQ: begin
                    expq.push_back(tbl[i].e);
                    #1;
                    check(i, "irq", {31'd0, irq});
                end
                OP_NOP: step();
                OP_RST: begin
                    reset = 1'b0;
                    tick = 1'b1;
                    step();
                    tick = 1'b0;
                    reset = 1'b1;
                end
                default: ;
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
